// File: rtl/tri_raster_engine.sv
// Flat-shaded streaming triangle rasteriser: clipped bounding-box scan at one pixel per cycle
// with framebuffer backpressure. Optional strict-less depth test under `define TRI_RASTER_ZBUF_EN.
module tri_raster_engine #(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int COORD_BITS            = 12,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int DEPTH_BITS            = 16,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
    parameter bit CULL_BACKFACE         = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tri_valid,
    output logic                             tri_ready,
    input  logic signed [COORD_BITS-1:0]     tri_ax,
    input  logic signed [COORD_BITS-1:0]     tri_ay,
    input  logic signed [COORD_BITS-1:0]     tri_bx,
    input  logic signed [COORD_BITS-1:0]     tri_by,
    input  logic signed [COORD_BITS-1:0]     tri_cx,
    input  logic signed [COORD_BITS-1:0]     tri_cy,
    input  logic [DEPTH_BITS-1:0]            tri_z,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] tri_color,
    output logic                             fb_wr_en,
    input  logic                             fb_ready,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_wr_addr,
    output logic [FRAMEBUFFER_DATA_BITS-1:0] fb_wr_data,
    output logic                             tri_done
`ifdef TRI_RASTER_ZBUF_EN
    ,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] zb_rd_addr,
    input  logic [DEPTH_BITS-1:0]            zb_rd_data,
    output logic                             zb_wr_en,
    output logic [DEPTH_BITS-1:0]            zb_wr_data
`endif
);

    localparam int DW = COORD_BITS + 1;
    localparam int EW = 2 * DW + 1;

    typedef logic signed [COORD_BITS-1:0] coord_t;
    typedef logic signed [EW-1:0]         edge_t;
    typedef enum logic [1:0] {IDLE, SETUP, SCAN, ZCMP} state_t;

    localparam coord_t X_MAX = coord_t'(DISPLAY_WIDTH - 1);
    localparam coord_t Y_MAX = coord_t'(DISPLAY_HEIGHT - 1);
    localparam coord_t ZERO  = '0;
    localparam coord_t ONE   = coord_t'(1);

    // Widened so the difference of two full-range products can never overflow.
    function automatic edge_t edge_fn(input coord_t x0, input coord_t y0, input coord_t x1,
                                      input coord_t y1, input coord_t qx, input coord_t qy);
        logic signed [DW-1:0]   dx, dy, ex, ey;
        logic signed [2*DW-1:0] p0, p1;
        dx = DW'(x1) - DW'(x0);
        dy = DW'(y1) - DW'(y0);
        ex = DW'(qx) - DW'(x0);
        ey = DW'(qy) - DW'(y0);
        p0 = (2*DW)'(dx) * (2*DW)'(ey);
        p1 = (2*DW)'(dy) * (2*DW)'(ex);
        return EW'(p0) - EW'(p1);
    endfunction

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    state_t state, state_next;
    coord_t ax, ay, bx, by, cx, cy;
    coord_t min_x, max_x, min_y, max_y, px, py;
    logic [FRAMEBUFFER_DATA_BITS-1:0] color_q;
    logic   step, done_next;

`ifdef TRI_RASTER_ZBUF_EN
    logic [DEPTH_BITS-1:0] z_q;
`else
    logic unused_z;
    assign unused_z = ^tri_z;
`endif

    coord_t lo_x, hi_x, lo_y, hi_y, clip_lo_x, clip_hi_x, clip_lo_y, clip_hi_y;
    edge_t  area, e0, e1, e2;
    logic   bbox_empty, skip, covered, last;
    logic [FRAMEBUFFER_ADDR_BITS-1:0] pix_addr;

    assign lo_x = min3(ax, bx, cx);
    assign hi_x = max3(ax, bx, cx);
    assign lo_y = min3(ay, by, cy);
    assign hi_y = max3(ay, by, cy);
    assign clip_lo_x = (lo_x < ZERO)  ? ZERO  : lo_x;
    assign clip_hi_x = (hi_x > X_MAX) ? X_MAX : hi_x;
    assign clip_lo_y = (lo_y < ZERO)  ? ZERO  : lo_y;
    assign clip_hi_y = (hi_y > Y_MAX) ? Y_MAX : hi_y;
    assign bbox_empty = (hi_x < ZERO) || (lo_x > X_MAX) || (hi_y < ZERO) || (lo_y > Y_MAX);

    assign area = edge_fn(ax, ay, bx, by, cx, cy);
    assign skip = (area == '0) || bbox_empty || (CULL_BACKFACE && (area < 0));

    assign e0 = edge_fn(ax, ay, bx, by, px, py);
    assign e1 = edge_fn(bx, by, cx, cy, px, py);
    assign e2 = edge_fn(cx, cy, ax, ay, px, py);
    // Either winding is accepted unless culling, in which case only the non-negative side counts.
    assign covered = (e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                     (!CULL_BACKFACE && e0 <= 0 && e1 <= 0 && e2 <= 0);
    assign last = (px == max_x) && (py == max_y);

    assign pix_addr = FRAMEBUFFER_ADDR_BITS'($unsigned(px)) +
                      FRAMEBUFFER_ADDR_BITS'($unsigned(py)) *
                      FRAMEBUFFER_ADDR_BITS'(DISPLAY_WIDTH);
    assign fb_wr_addr = pix_addr;
    assign fb_wr_data = color_q;
`ifdef TRI_RASTER_ZBUF_EN
    assign zb_rd_addr = pix_addr;
    assign zb_wr_data = z_q;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        tri_ready  = 1'b0;
        fb_wr_en   = 1'b0;
        step       = 1'b0;
        done_next  = 1'b0;
`ifdef TRI_RASTER_ZBUF_EN
        zb_wr_en   = 1'b0;
`endif
        case (state)
            IDLE: begin
                tri_ready = 1'b1;
                if (tri_valid) state_next = SETUP;
            end
            SETUP: begin
                if (skip) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
`ifdef TRI_RASTER_ZBUF_EN
                if (covered) state_next = ZCMP;
                else         step       = 1'b1;
`else
                fb_wr_en = covered;
                step     = !covered || fb_ready;
`endif
            end
`ifdef TRI_RASTER_ZBUF_EN
            ZCMP: begin
                if (z_q < zb_rd_data) begin
                    fb_wr_en = 1'b1;
                    zb_wr_en = 1'b1;
                    step     = fb_ready;
                end else begin
                    step = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if (step) begin
            if (last) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = SCAN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tri_done <= 1'b0;
            {ax, ay, bx, by, cx, cy} <= '0;
            {min_x, max_x, min_y, max_y, px, py} <= '0;
            color_q  <= '0;
`ifdef TRI_RASTER_ZBUF_EN
            z_q      <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state    <= state_next;
            tri_done <= done_next;
            if (state == IDLE && tri_valid) begin
                ax      <= tri_ax;
                ay      <= tri_ay;
                bx      <= tri_bx;
                by      <= tri_by;
                cx      <= tri_cx;
                cy      <= tri_cy;
                color_q <= tri_color;
`ifdef TRI_RASTER_ZBUF_EN
                z_q     <= tri_z;
`endif
            end
            if (state == SETUP) begin
                min_x <= clip_lo_x;
                max_x <= clip_hi_x;
                min_y <= clip_lo_y;
                max_y <= clip_hi_y;
                px    <= clip_lo_x;
                py    <= clip_lo_y;
            end
            if (step && !last) begin
                if (px == max_x) begin
                    px <= min_x;
                    py <= py + ONE;
                end else begin
                    px <= px + ONE;
                end
            end
        end
    end

endmodule
